// File: rtl/uart_mmio_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

    localparam int unsigned STAT_FULL_BIT   = 0;
    localparam int unsigned STAT_EMPTY_BIT  = 1;
    localparam int unsigned STAT_ACTIVE_BIT = 2;
    localparam int unsigned STAT_OVF_BIT    = 3;
    localparam int unsigned STAT_COUNT_LSB  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA push register, STATUS register, FIFO-fed serialiser.
module mmio_uart_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          tx_q, tx_n;
    logic          ovf_q;

    logic          sel_tx;
    logic          sel_st;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          tx_active;
    logic [31:0]   status;
    logic          wdata_unused;

    assign sel_tx       = (addr == BASE_ADDR + OFF_TXDATA);
    assign sel_st       = (addr == BASE_ADDR + OFF_STATUS);
    assign hit          = sel_tx || sel_st;
    assign fifo_push    = we && sel_tx && !fifo_full;
    assign tx_active    = (state_q != IDLE);
    assign busy         = tx_active || !fifo_empty;
    assign tx           = tx_q;
    assign rdata        = sel_st ? status : '0;
    assign wdata_unused = ^wdata[31:8];

    always_comb begin
        status                                 = '0;
        status[STAT_FULL_BIT]                  = fifo_full;
        status[STAT_EMPTY_BIT]                 = fifo_empty;
        status[STAT_ACTIVE_BIT]                = tx_active;
        status[STAT_OVF_BIT]                   = ovf_q;
        status[STAT_COUNT_LSB +: 4]            = 4'(fifo_count);
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Drop and clear live at different addresses, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (we && sel_tx && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (we && sel_st && wdata[STAT_OVF_BIT]) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // tx is registered, so each branch computes the line level for the next cycle.
    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
        tx_n     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_head;
                    timer_n  = '0;
                    tx_n     = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_n = '0;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                    state_n = DATA;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_n = '0;
                    if (bit_q == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = {1'b0, shift_q[7:1]};
                        tx_n    = shift_q[1];
                    end
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_head;
                        tx_n     = 1'b0;
                        state_n  = START;
                    end else begin
                        state_n  = IDLE;
                    end
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register map, framing, burst, overflow, reset, decode.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic        log_en = 1'b0;
    logic        arm    = 1'b0;
    logic        txq[$];
    logic        bq[$];
    logic [7:0]  exp_bytes[$];

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_0100),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .hit   (hit),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en) begin
            txq.push_back(tx);
            bq.push_back(busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One bus cycle; logging starts at the edge of the first armed write.
    task automatic drive(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        if (arm) begin
            txq.delete();
            bq.delete();
            log_en = 1'b1;
            arm    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic read_status(input string tag, input logic [31:0] expv);
        we   = 1'b0;
        addr = 32'h0000_0104;
        #1;
        chk(tag, rdata, expv);
    endtask

    // Sample 0 is taken after the first write edge; frame k occupies samples 1+k*FRAME ..
    task automatic check_stream(input string tag, input int unsigned total);
        int unsigned guard = 0;
        logic        e;
        int unsigned k;
        int unsigned j;
        while (txq.size() < total && guard < total + 10) begin
            @(negedge clk);
            guard++;
        end
        log_en = 1'b0;
        chk({tag, "_len"}, 32'(txq.size() >= total), 32'd1);
        for (int unsigned i = 0; i < total && i < txq.size(); i++) begin
            e = 1'b1;
            if (i >= 1) begin
                k = (i - 1) / FRAME;
                j = ((i - 1) % FRAME) / CPB;
                if (k < exp_bytes.size()) begin
                    if (j == 0) e = 1'b0;
                    else if (j <= 8) e = exp_bytes[k][j-1];
                end
            end
            chk($sformatf("%s_s%0d", tag, i), 32'(txq[i]), 32'(e));
        end
    endtask

    initial begin
        int unsigned n;

        rst   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_status("reset_status", 32'h0000_0002);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hit", 32'(hit), 32'd1);
        @(negedge clk);

        // Single frame 0x55
        exp_bytes = '{8'h55};
        arm = 1'b1;
        drive(32'h0000_0100, 32'h0000_0055);
        we = 1'b0;
        check_stream("single", 50);
        n = 0;
        for (int unsigned i = 1; i <= 41; i++) if (bq[i] === 1'b1) n++;
        chk("single_busy_cycles", n, 32'd40);
        chk("single_busy_end", 32'(bq[41]), 32'd0);
        @(negedge clk);

        // Burst of five bytes, one pops immediately so four remain queued
        exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        arm = 1'b1;
        for (int unsigned i = 0; i < 5; i++) drive(32'h0000_0100, 32'(8'h41 + i));
        read_status("burst_status", 32'h0000_0045);
        check_stream("burst", 1 + 5 * FRAME + 20);
        @(negedge clk);

        // Overflow: sixth write finds the FIFO full and is dropped
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        arm = 1'b1;
        drive(32'h0000_0100, 32'h0000_0011);
        drive(32'h0000_0100, 32'h0000_0022);
        drive(32'h0000_0100, 32'h0000_0033);
        drive(32'h0000_0100, 32'h0000_0044);
        drive(32'h0000_0100, 32'h0000_005A);
        drive(32'h0000_0100, 32'h0000_0099);
        read_status("ovf_set", 32'h0000_004D);
        drive(32'h0000_0104, 32'h0000_0008);
        read_status("ovf_clear", 32'h0000_0045);
        check_stream("ovf", 1 + 6 * FRAME + 20);
        @(negedge clk);

        // Reset during data bit 3 of 0xA5 with 0x3C still queued
        arm = 1'b1;
        drive(32'h0000_0100, 32'h0000_00A5);
        drive(32'h0000_0100, 32'h0000_003C);
        we = 1'b0;
        log_en = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst_bit3", 32'(tx), 32'd0);
        read_status("midrst_pre_status", 32'h0000_0014);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        read_status("midrst_status", 32'h0000_0002);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        chk("midrst_quiet", n, 32'd0);

        // Address decode: out-of-window store and read
        drive(32'h0000_0200, 32'h0000_0077);
        we   = 1'b0;
        addr = 32'h0000_0108;
        #1;
        chk("dec_hit_108", 32'(hit), 32'd0);
        chk("dec_rdata_108", rdata, 32'h0);
        addr = 32'h0000_0100;
        #1;
        chk("dec_hit_100", 32'(hit), 32'd1);
        chk("dec_rdata_100", rdata, 32'h0);
        read_status("dec_status", 32'h0000_0002);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        chk("dec_tx_idle", n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
